// File: rtl/tta_bus_arbiter.sv
// Two-master (instruction/data) arbiter onto one shared memory port.
// Ties alternate against the last owner; a grant is forced to end after
// TIMEOUT_CYCLES cycles without m_ready_i, completing with zero read data.
module tta_bus_arbiter #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        i_valid_i,
    input  logic [18:0] i_addr_i,
    output logic [31:0] i_rdata_o,
    output logic        i_ready_o,
    input  logic        d_valid_i,
    input  logic [18:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    input  logic [3:0]  d_wstrb_i,
    output logic [31:0] d_rdata_o,
    output logic        d_ready_o,
    output logic        m_valid_o,
    output logic [18:0] m_addr_o,
    output logic [31:0] m_wdata_o,
    output logic [3:0]  m_wstrb_o,
    output logic        m_instr_o,
    input  logic [31:0] m_rdata_i,
    input  logic        m_ready_i,
    output logic [1:0]  grant_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StGntI = 2'd1,
        StGntD = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_d;
    logic        r_last_d;     // 1 when the data master owned the most recent grant
    logic [15:0] r_cnt;
    logic [18:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_instr;
    logic        w_timeout;
    logic        w_done;

    // Timeout and completion detection for the current grant.
    always_comb begin
        w_timeout = (r_state != StIdle) && !m_ready_i &&
                    (r_cnt == (TIMEOUT_CYCLES - 16'd1));
        w_done    = (r_state != StIdle) && (m_ready_i || w_timeout);
    end

    // Next-state: arbitrate in idle, return to idle when a grant completes.
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle: begin
                if (i_valid_i && d_valid_i) begin
                    w_state_d = r_last_d ? StGntI : StGntD;
                end else if (i_valid_i) begin
                    w_state_d = StGntI;
                end else if (d_valid_i) begin
                    w_state_d = StGntD;
                end
            end
            StGntI, StGntD: begin
                if (w_done) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // State, owner history, wait counter and captured request fields.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state  <= StIdle;
            r_last_d <= 1'b1;
            r_cnt    <= 16'd0;
            r_addr   <= 19'd0;
            r_wdata  <= 32'd0;
            r_wstrb  <= 4'd0;
            r_instr  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            // Cleared while idle so every grant starts counting from zero.
            if (r_state == StIdle) begin
                r_cnt <= 16'd0;
            end else if (!m_ready_i && (r_cnt != 16'hFFFF)) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if ((r_state == StIdle) && (w_state_d == StGntI)) begin
                r_last_d <= 1'b0;
                r_addr   <= i_addr_i;
                r_wdata  <= 32'd0;
                r_wstrb  <= 4'd0;
                r_instr  <= 1'b1;
            end else if ((r_state == StIdle) && (w_state_d == StGntD)) begin
                r_last_d <= 1'b1;
                r_addr   <= d_addr_i;
                r_wdata  <= d_wdata_i;
                r_wstrb  <= d_wstrb_i;
                r_instr  <= 1'b0;
            end
        end
    end

    // Output decode: memory request fields, grant, and per-master responses.
    always_comb begin
        m_valid_o = (r_state != StIdle);
        m_addr_o  = r_addr;
        m_wdata_o = r_wdata;
        m_wstrb_o = r_wstrb;
        m_instr_o = r_instr;
        grant_o   = {r_state == StGntD, r_state == StGntI};
        timeout_o = w_timeout;
        i_ready_o = (r_state == StGntI) && (m_ready_i || w_timeout);
        d_ready_o = (r_state == StGntD) && (m_ready_i || w_timeout);
        i_rdata_o = ((r_state == StGntI) && w_timeout) ? 32'd0 : m_rdata_i;
        d_rdata_o = ((r_state == StGntD) && w_timeout) ? 32'd0 : m_rdata_i;
    end

endmodule

// File: tb/tb_tta_bus_arbiter.sv
// Scoreboard bench for tta_bus_arbiter: a transaction-level model predicts
// each grant's owner, request fields, response and duration; a monitor pops
// and compares whenever a ready strobe appears.
module tb_tta_bus_arbiter;

    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        i_valid_i;
    logic [18:0] i_addr_i;
    logic [31:0] i_rdata_o;
    logic        i_ready_o;
    logic        d_valid_i;
    logic [18:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [3:0]  d_wstrb_i;
    logic [31:0] d_rdata_o;
    logic        d_ready_o;
    logic        m_valid_o;
    logic [18:0] m_addr_o;
    logic [31:0] m_wdata_o;
    logic [3:0]  m_wstrb_o;
    logic        m_instr_o;
    logic [31:0] m_rdata_i;
    logic        m_ready_i;
    logic [1:0]  grant_o;
    logic        timeout_o;

    tta_bus_arbiter #(.TIMEOUT_CYCLES(16'(TO))) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .i_valid_i(i_valid_i), .i_addr_i(i_addr_i),
        .i_rdata_o(i_rdata_o), .i_ready_o(i_ready_o),
        .d_valid_i(d_valid_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_wstrb_i(d_wstrb_i), .d_rdata_o(d_rdata_o), .d_ready_o(d_ready_o),
        .m_valid_o(m_valid_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
        .m_wstrb_o(m_wstrb_o), .m_instr_o(m_instr_o),
        .m_rdata_i(m_rdata_i), .m_ready_i(m_ready_i),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          is_d;
        logic [18:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        bit          instr;
        logic [31:0] rdata;
        bit          to;
        int          cycles;
        longint      gap;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    bit   last_was_d;   // model: who owned the previous grant

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One transaction, entered one step after a rising edge with the DUT idle.
    task automatic do_txn(input bit iv, input bit dv, input logic [18:0] ia,
                          input logic [18:0] da, input logic [31:0] dw,
                          input logic [3:0] ds, input int lat,
                          input logic [31:0] rd, input longint gap);
        exp_t e;
        bit   done;
        e.is_d   = (iv && dv) ? !last_was_d : dv;
        last_was_d = e.is_d;
        e.addr   = e.is_d ? da : ia;
        e.wdata  = e.is_d ? dw : 32'd0;
        e.wstrb  = e.is_d ? ds : 4'd0;
        e.instr  = !e.is_d;
        e.to     = (lat > TO - 1);
        e.rdata  = e.to ? 32'd0 : rd;
        e.cycles = e.to ? TO : lat + 1;
        e.gap    = gap;
        exp_q.push_back(e);
        i_valid_i = iv;
        d_valid_i = dv;
        i_addr_i  = ia;
        d_addr_i  = da;
        d_wdata_i = dw;
        d_wstrb_i = ds;
        m_ready_i = 1'($urandom);     // must be ignored while idle
        m_rdata_i = $urandom;
        @(posedge clk_i); #1;
        // Requesters withdraw and scramble their buses mid-grant.
        i_valid_i = 1'b0;
        d_valid_i = 1'b0;
        i_addr_i  = 19'($urandom);
        d_addr_i  = 19'($urandom);
        d_wdata_i = $urandom;
        d_wstrb_i = 4'($urandom);
        for (int k = 0; k < TO + 8; k++) begin
            m_ready_i = (k == lat);
            m_rdata_i = (k == lat) ? rd : $urandom;
            done = (k == lat) || (k == TO - 1);
            @(posedge clk_i); #1;
            if (done) break;
        end
        m_ready_i = 1'b0;
    endtask

    // Monitor: stability during grants, quiet when idle, scoreboard on ready.
    initial begin : monitor
        int          gcyc;
        logic [55:0] snap;
        longint      prev_t;
        exp_t        e;
        gcyc = 0;
        snap = '0;
        prev_t = 0;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                gcyc = 0;
            end else if (m_valid_o) begin
                if (gcyc == 0) snap = {m_addr_o, m_wdata_o, m_wstrb_o, m_instr_o};
                else chk("m_fields_stable", 64'({m_addr_o, m_wdata_o, m_wstrb_o, m_instr_o}),
                         64'(snap));
                gcyc++;
                if (i_ready_o || d_ready_o) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_ready", 64'({i_ready_o, d_ready_o}), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("grant", 64'(grant_o), e.is_d ? 64'd2 : 64'd1);
                        chk("ready_onehot", 64'({d_ready_o, i_ready_o}), e.is_d ? 64'd2 : 64'd1);
                        chk("m_addr", 64'(m_addr_o), 64'(e.addr));
                        chk("m_wdata", 64'(m_wdata_o), 64'(e.wdata));
                        chk("m_wstrb", 64'(m_wstrb_o), 64'(e.wstrb));
                        chk("m_instr", 64'(m_instr_o), 64'(e.instr));
                        chk("rdata", 64'(e.is_d ? d_rdata_o : i_rdata_o), 64'(e.rdata));
                        chk("timeout", 64'(timeout_o), 64'(e.to));
                        chk("grant_cycles", 64'(gcyc), 64'(e.cycles));
                        if (e.gap != 0) chk("throughput_gap", 64'($time - prev_t), 64'(e.gap));
                    end
                    prev_t = $time;
                    gcyc = 0;
                end
            end else begin
                chk("idle_quiet", 64'({i_ready_o, d_ready_o, timeout_o, grant_o}), 64'd0);
            end
        end
    end

    initial begin : stim
        rst_i = 1'b0;
        i_valid_i = 1'b0; i_addr_i = '0;
        d_valid_i = 1'b0; d_addr_i = '0; d_wdata_i = '0; d_wstrb_i = '0;
        m_rdata_i = '0; m_ready_i = 1'b0;
        last_was_d = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_m_valid", 64'(m_valid_o), 64'd0);
        chk("rst_grant", 64'(grant_o), 64'd0);
        chk("rst_m_fields", 64'({m_addr_o, m_wdata_o, m_wstrb_o, m_instr_o}), 64'd0);
        rst_i = 1'b1;

        // Alternating ties, ready after two wait cycles; instruction wins first.
        for (int n = 0; n < 4; n++)
            do_txn(1'b1, 1'b1, 19'h00010, 19'h00020, 32'h1111_0000, 4'hF, 2, $urandom, 0);
        // Data write held for three cycles.
        do_txn(1'b0, 1'b1, 19'h0, 19'h00100, 32'hCAFEBABE, 4'b0011, 2, 32'h0, 0);
        // Timeout with ready never arriving, then ready exactly in the last cycle.
        do_txn(1'b1, 1'b0, 19'h00040, 19'h0, 32'h0, 4'h0, 100, $urandom, 0);
        do_txn(1'b1, 1'b0, 19'h00044, 19'h0, 32'h0, 4'h0, TO - 1, 32'h12345678, 0);
        // Data-only back-to-back, one transaction every two cycles.
        for (int n = 0; n < 5; n++)
            do_txn(1'b0, 1'b1, 19'h0, 19'(n * 4), $urandom, 4'($urandom), 0, $urandom,
                   (n == 0) ? 0 : 20);

        // Asynchronous reset in the middle of a data grant.
        d_valid_i = 1'b1;
        d_addr_i  = 19'h00200;
        @(posedge clk_i); #1;
        d_valid_i = 1'b0;
        chk("pre_rst_grant", 64'(grant_o), 64'd2);
        #2 rst_i = 1'b0;
        #1;
        chk("async_rst_m_valid", 64'(m_valid_o), 64'd0);
        chk("async_rst_grant", 64'(grant_o), 64'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        last_was_d = 1'b1;
        do_txn(1'b1, 1'b1, 19'h00300, 19'h00304, 32'h0, 4'h0, 1, $urandom, 0);

        // Randomized traffic.
        for (int n = 0; n < 200; n++) begin
            int pat;
            pat = $urandom_range(1, 3);
            do_txn(pat[0], pat[1], 19'($urandom), 19'($urandom), $urandom, 4'($urandom),
                   $urandom_range(0, TO + 1), $urandom, 0);
        end

        repeat (3) @(posedge clk_i);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
